// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one combinational ALU among
// NUM_REQ requesters, with a one-entry tagged response register that is
// held until the consumer accepts it.

package riscv_pkg;
   // ALU operation encoding; OP_ADD is the all-zero code.
   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_AND  = 4'd2,
      OP_OR   = 4'd3,
      OP_XOR  = 4'd4,
      OP_SLL  = 4'd5,
      OP_SRL  = 4'd6,
      OP_SRA  = 4'd7,
      OP_SLT  = 4'd8,
      OP_SLTU = 4'd9
   } t_risc_v_op;
endpackage

module alu_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                                clk_i,
   input  logic                                rst_ni,
   input  logic [NUM_REQ-1:0]                  req_valid_i,
   output logic [NUM_REQ-1:0]                  req_ready_o,
   input  riscv_pkg::t_risc_v_op [NUM_REQ-1:0] req_op_i,
   input  logic [NUM_REQ-1:0][31:0]            req_src1_i,
   input  logic [NUM_REQ-1:0][31:0]            req_src2_i,
   output riscv_pkg::t_risc_v_op               alu_op_o,
   output logic [31:0]                         alu_src1_o,
   output logic [31:0]                         alu_src2_o,
   input  logic [31:0]                         alu_result_i,
   output logic                                rsp_valid_o,
   output logic [ID_W-1:0]                     rsp_id_o,
   output logic [31:0]                         rsp_result_o,
   input  logic                                rsp_ready_i
);

   logic [ID_W-1:0] rr_ptr;
   logic [ID_W-1:0] rr_next;
   logic [ID_W-1:0] win_id;
   logic            win_found;
   logic [ID_W-1:0] hi_id;
   logic            hi_found;
   logic [ID_W-1:0] lo_id;
   logic            lo_found;
   logic            can_accept;
   logic            accept;

   // Holding reset also forces every ready low, not only the registers.
   assign can_accept = rst_ni && (!rsp_valid_o || rsp_ready_i);
   assign accept     = win_found && can_accept;

   // Round-robin pick: lowest valid index at or above rr_ptr, else lowest valid overall.
   always_comb begin
      // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
      hi_found = 1'b0;
      hi_id    = '0;
      lo_found = 1'b0;
      lo_id    = '0;
      // Descending scan so the last hit kept is the lowest index.
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_valid_i[i]) begin
            lo_found = 1'b1;
            lo_id    = ID_W'(i);
            if (ID_W'(i) >= rr_ptr) begin
               hi_found = 1'b1;
               hi_id    = ID_W'(i);
            end
         end
      end
      win_found = lo_found;
      win_id    = hi_found ? hi_id : lo_id;
   end

   // Steer the winner onto the ALU and raise its ready; all-zero when idle.
   always_comb begin
      req_ready_o = '0;
      alu_op_o    = riscv_pkg::t_risc_v_op'('0);
      alu_src1_o  = '0;
      alu_src2_o  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win_found && (win_id == ID_W'(i))) begin
            req_ready_o[i] = can_accept;
            alu_op_o       = req_op_i[i];
            alu_src1_o     = req_src1_i[i];
            alu_src2_o     = req_src2_i[i];
         end
      end
   end

   // Next priority pointer: one past the winner, wrapping at NUM_REQ-1.
   always_comb begin
      if (win_id == ID_W'(NUM_REQ - 1)) begin
         rr_next = '0;
      end else begin
         rr_next = win_id + ID_W'(1);
      end
   end

   // Response register and priority pointer; a drain and an accept in the same edge keep valid high.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         // NOTE: the result register is reset too, so a discarded response never reads back as stale data.
         rr_ptr       <= '0;
         rsp_valid_o  <= 1'b0;
         rsp_id_o     <= '0;
         rsp_result_o <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         if (accept) begin
            rsp_valid_o  <= 1'b1;
            rsp_id_o     <= win_id;
            rsp_result_o <= alu_result_i;
            rr_ptr       <= rr_next;
         end else if (rsp_ready_i) begin
            rsp_valid_o  <= 1'b0;
         end
      end
   end

endmodule
